// File: rtl/cpu_isa_pkg.sv
// ---------------------------------------------------------------------------
// cpu_isa_pkg
// Shared definitions for the CR16-style control unit:
//   - major opcode (op) and extended opcode (ext) field values
//   - branch condition codes and PSR flag bit positions
//   - FSM state encoding and decoded instruction classes
//   - cond_true(): evaluates a branch condition against the latched flags
//   - sext8(): sign-extends an 8-bit immediate/displacement to 16 bits
// ---------------------------------------------------------------------------
package cpu_isa_pkg;

    // Major opcodes, IR[15:12]
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ANDI  = 4'b0001;
    localparam logic [3:0] OP_ORI   = 4'b0010;
    localparam logic [3:0] OP_XORI  = 4'b0011;
    localparam logic [3:0] OP_MEM   = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;
    localparam logic [3:0] OP_MOVI  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1111;

    // Extended opcodes, IR[7:4]; R-type ALU ops share the I-type op values
    localparam logic [3:0] EXT_AND  = 4'b0001;
    localparam logic [3:0] EXT_OR   = 4'b0010;
    localparam logic [3:0] EXT_XOR  = 4'b0011;
    localparam logic [3:0] EXT_ADD  = 4'b0101;
    localparam logic [3:0] EXT_SUB  = 4'b1001;
    localparam logic [3:0] EXT_CMP  = 4'b1011;
    localparam logic [3:0] EXT_MOV  = 4'b1101;
    localparam logic [3:0] EXT_LOAD = 4'b0000;
    localparam logic [3:0] EXT_STOR = 4'b0100;

    // Flag bit positions inside {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Branch condition codes, IR[11:8] of a Bcond
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_HI = 4'b0100;
    localparam logic [3:0] COND_LS = 4'b0101;
    localparam logic [3:0] COND_GT = 4'b0110;
    localparam logic [3:0] COND_LE = 4'b0111;
    localparam logic [3:0] COND_FS = 4'b1000;
    localparam logic [3:0] COND_FC = 4'b1001;
    localparam logic [3:0] COND_LO = 4'b1010;
    localparam logic [3:0] COND_HS = 4'b1011;
    localparam logic [3:0] COND_LT = 4'b1100;
    localparam logic [3:0] COND_GE = 4'b1101;
    localparam logic [3:0] COND_UC = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Control FSM states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    // Coarse instruction classes produced by the decoder
    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STOR   = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_WAIT   = 3'd5
    } instr_class_t;

    // Branch taken test; HI/LS use the unsigned-lower flag L, GT/LE use N
    function automatic logic cond_true(input logic [3:0] cond, input logic [4:0] flags);
        logic res;
        res = 1'b0;
        case (cond)
            COND_EQ: res = flags[FLAG_Z];
            COND_NE: res = ~flags[FLAG_Z];
            COND_CS: res = flags[FLAG_C];
            COND_CC: res = ~flags[FLAG_C];
            COND_HI: res = flags[FLAG_L];
            COND_LS: res = ~flags[FLAG_L];
            COND_GT: res = flags[FLAG_N];
            COND_LE: res = ~flags[FLAG_N];
            COND_FS: res = flags[FLAG_F];
            COND_FC: res = ~flags[FLAG_F];
            COND_LO: res = ~flags[FLAG_L] & ~flags[FLAG_Z];
            COND_HS: res = flags[FLAG_L] | flags[FLAG_Z];
            COND_LT: res = ~flags[FLAG_N] & ~flags[FLAG_Z];
            COND_GE: res = flags[FLAG_N] | flags[FLAG_Z];
            COND_UC: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Purely combinational decode of the instruction register.
// Ports:
//   ir_i          in  16  latched instruction word
//   opcode_o      out  8  ALU opcode
//   imm_o         out 16  extended immediate
//   imm_select_o  out  1  ALU B operand is the immediate
//   class_o       out  3  instr_class_t value
//   writes_reg_o  out  1  instruction writes register rd
//   sets_flags_o  out  1  instruction updates the PSR
// ---------------------------------------------------------------------------
module instr_decode
    import cpu_isa_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [7:0]  opcode_o,
    output logic [15:0] imm_o,
    output logic        imm_select_o,
    output logic [2:0]  class_o,
    output logic        writes_reg_o,
    output logic        sets_flags_o
);

    logic [3:0] opField;
    logic [3:0] extField;
    logic [7:0] imm8;

    assign opField  = ir_i[15:12];
    assign extField = ir_i[7:4];
    assign imm8     = ir_i[7:0];

    // Classify the word and build the ALU controls. Anything not recognised
    // falls through to the CLS_NOP defaults. LUI reuses the MOV ALU path
    // with the immediate already shifted into the upper byte.
    always_comb begin
        opcode_o     = 8'h00;
        imm_o        = 16'h0000;
        imm_select_o = 1'b0;
        class_o      = CLS_NOP;
        writes_reg_o = 1'b0;
        sets_flags_o = 1'b0;
        case (opField)
            OP_RTYPE: begin
                if (ir_i == 16'h0000) begin
                    class_o = CLS_WAIT;
                end else begin
                    case (extField)
                        EXT_ADD, EXT_SUB: begin
                            class_o      = CLS_ALU;
                            opcode_o     = {4'b0000, extField};
                            writes_reg_o = 1'b1;
                            sets_flags_o = 1'b1;
                        end
                        EXT_CMP: begin
                            class_o      = CLS_ALU;
                            opcode_o     = {4'b0000, extField};
                            sets_flags_o = 1'b1;
                        end
                        EXT_AND, EXT_OR, EXT_XOR, EXT_MOV: begin
                            class_o      = CLS_ALU;
                            opcode_o     = {4'b0000, extField};
                            writes_reg_o = 1'b1;
                        end
                        default: class_o = CLS_NOP;
                    endcase
                end
            end
            OP_ADDI, OP_SUBI: begin
                class_o      = CLS_ALU;
                opcode_o     = {opField, 4'b0000};
                imm_o        = sext8(imm8);
                imm_select_o = 1'b1;
                writes_reg_o = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_CMPI: begin
                class_o      = CLS_ALU;
                opcode_o     = {opField, 4'b0000};
                imm_o        = sext8(imm8);
                imm_select_o = 1'b1;
                sets_flags_o = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
                class_o      = CLS_ALU;
                opcode_o     = {opField, 4'b0000};
                imm_o        = {8'h00, imm8};
                imm_select_o = 1'b1;
                writes_reg_o = 1'b1;
            end
            OP_LUI: begin
                class_o      = CLS_ALU;
                opcode_o     = {OP_MOVI, 4'b0000};
                imm_o        = {imm8, 8'h00};
                imm_select_o = 1'b1;
                writes_reg_o = 1'b1;
            end
            OP_MEM: begin
                if (extField == EXT_LOAD) begin
                    class_o      = CLS_LOAD;
                    writes_reg_o = 1'b1;
                end else if (extField == EXT_STOR) begin
                    class_o = CLS_STOR;
                end
            end
            OP_BCOND: class_o = CLS_BRANCH;
            default:  class_o = CLS_NOP;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// cpu_control_fsm
// Multi-cycle control unit: FETCH -> DECODE -> EXEC | MEM [-> WB] -> FETCH.
// Holds the instruction register and the processor status flags.
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   ram_out             instruction word from RAM / instruction buffer
//   flags_in            ALU flags {C,L,F,Z,N}
//   pc_count            current PC (observed only)
//   opcode, Imm_in, Imm_select            ALU controls
//   wEnable, Rdest_select, Rsrc_select    register file controls
//   fsm_alu_mem_selct, lsc_mux_selct      writeback / address muxes
//   en_a, we_a                            RAM port controls
//   pc_en, pc_mux_selct, pc_add_k         PC update controls
//   psr                 latched flags
//   halted              FSM parked in S_HALT
// ---------------------------------------------------------------------------
module cpu_control_fsm
    import cpu_isa_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0,
    parameter bit         EN_WAIT     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ram_out,
    input  logic [4:0]  flags_in,
    input  logic [15:0] pc_count,
    output logic [7:0]  opcode,
    output logic [15:0] wEnable,
    output logic [3:0]  Rdest_select,
    output logic [3:0]  Rsrc_select,
    output logic [15:0] Imm_in,
    output logic        Imm_select,
    output logic        fsm_alu_mem_selct,
    output logic        lsc_mux_selct,
    output logic        en_a,
    output logic        we_a,
    output logic        pc_en,
    output logic        pc_mux_selct,
    output logic [15:0] pc_add_k,
    output logic [4:0]  psr,
    output logic        halted
);

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [4:0]  psr_q, psr_d;

    logic [7:0]  decOpcode;
    logic [15:0] decImm;
    logic        decImmSelect;
    logic [2:0]  decClass;
    logic        decWritesReg;
    logic        decSetsFlags;

    logic [3:0]  rdField;
    logic [3:0]  rsField;
    logic [15:0] rdOneHot;
    logic        wordIsMem;
    logic        unusedPc;

    assign rdField  = ir_q[11:8];
    assign rsField  = ir_q[3:0];
    assign rdOneHot = 16'h0001 << rdField;
    assign psr      = psr_q;
    assign unusedPc = ^pc_count;

    // The incoming word decides the path out of DECODE, before it is in IR
    assign wordIsMem = (ram_out[15:12] == OP_MEM) &&
                       ((ram_out[7:4] == EXT_LOAD) || (ram_out[7:4] == EXT_STOR));

    instr_decode uDecode (
        .ir_i         (ir_q),
        .opcode_o     (decOpcode),
        .imm_o        (decImm),
        .imm_select_o (decImmSelect),
        .class_o      (decClass),
        .writes_reg_o (decWritesReg),
        .sets_flags_o (decSetsFlags)
    );

    // State, IR and PSR registers. Outputs are decoded from state, so the
    // asynchronous reset also pulls we_a low the moment reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= state_t'(RESET_STATE);
            ir_q    <= 16'h0000;
            psr_q   <= 5'b00000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            psr_q   <= psr_d;
        end
    end

    // Next-state and output decode. Every output defaults to 0 so each
    // state only lists what it asserts. Branches test the latched PSR so a
    // compare updates it exactly in time for the following Bcond.
    always_comb begin
        state_d           = state_q;
        ir_d              = ir_q;
        psr_d             = psr_q;
        opcode            = 8'h00;
        wEnable           = 16'h0000;
        Rdest_select      = 4'h0;
        Rsrc_select       = 4'h0;
        Imm_in            = 16'h0000;
        Imm_select        = 1'b0;
        fsm_alu_mem_selct = 1'b0;
        lsc_mux_selct     = 1'b0;
        en_a              = 1'b0;
        we_a              = 1'b0;
        pc_en             = 1'b0;
        pc_mux_selct      = 1'b0;
        pc_add_k          = 16'h0000;
        halted            = 1'b0;
        case (state_q)
            S_FETCH: begin
                en_a    = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d = ram_out;
                if (wordIsMem) begin
                    state_d = S_MEM;
                end else if (EN_WAIT && (ram_out == 16'h0000)) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_en   = 1'b1;
                state_d = S_FETCH;
                if (decClass == CLS_ALU) begin
                    opcode       = decOpcode;
                    Imm_in       = decImm;
                    Imm_select   = decImmSelect;
                    Rdest_select = rdField;
                    if (!decImmSelect) begin
                        Rsrc_select = rsField;
                    end
                    if (decWritesReg) begin
                        wEnable = rdOneHot;
                    end
                    if (decSetsFlags) begin
                        psr_d = flags_in;
                    end
                end else if (decClass == CLS_BRANCH) begin
                    pc_add_k     = sext8(ir_q[7:0]);
                    pc_mux_selct = cond_true(rdField, psr_q);
                end
            end
            S_MEM: begin
                lsc_mux_selct = 1'b1;
                en_a          = 1'b1;
                Rdest_select  = rsField;
                if (decClass == CLS_STOR) begin
                    Rsrc_select = rdField;
                    we_a        = 1'b1;
                    pc_en       = 1'b1;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                lsc_mux_selct     = 1'b1;
                fsm_alu_mem_selct = 1'b1;
                wEnable           = rdOneHot;
                pc_en             = 1'b1;
                state_d           = S_FETCH;
            end
            S_HALT: begin
                halted  = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_cpu_control_fsm
// Table of instruction vectors with hand-computed controls; each cycle's
// expected output snapshot is queued when driven and compared at negedge.
// ---------------------------------------------------------------------------
module tb_cpu_control_fsm;
    import cpu_isa_pkg::*;

    localparam int K_EXEC = 0;
    localparam int K_LOAD = 1;
    localparam int K_STOR = 2;
    localparam int NVEC   = 22;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ram_out;
    logic [4:0]  flags_in;
    logic [15:0] pc_count;
    logic [7:0]  opcode;
    logic [15:0] wEnable;
    logic [3:0]  Rdest_select;
    logic [3:0]  Rsrc_select;
    logic [15:0] Imm_in;
    logic        Imm_select;
    logic        fsm_alu_mem_selct;
    logic        lsc_mux_selct;
    logic        en_a;
    logic        we_a;
    logic        pc_en;
    logic        pc_mux_selct;
    logic [15:0] pc_add_k;
    logic [4:0]  psr;
    logic        halted;

    always #5 clk = ~clk;

    cpu_control_fsm #(.RESET_STATE(3'd0), .EN_WAIT(1'b1)) dut (
        .clk               (clk),
        .reset             (reset),
        .ram_out           (ram_out),
        .flags_in          (flags_in),
        .pc_count          (pc_count),
        .opcode            (opcode),
        .wEnable           (wEnable),
        .Rdest_select      (Rdest_select),
        .Rsrc_select       (Rsrc_select),
        .Imm_in            (Imm_in),
        .Imm_select        (Imm_select),
        .fsm_alu_mem_selct (fsm_alu_mem_selct),
        .lsc_mux_selct     (lsc_mux_selct),
        .en_a              (en_a),
        .we_a              (we_a),
        .pc_en             (pc_en),
        .pc_mux_selct      (pc_mux_selct),
        .pc_add_k          (pc_add_k),
        .psr               (psr),
        .halted            (halted)
    );

    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] wEnable;
        logic [3:0]  rdest;
        logic [3:0]  rsrc;
        logic [15:0] imm;
        logic        immSel;
        logic        fam;
        logic        lsc;
        logic        enA;
        logic        weA;
        logic        pcEn;
        logic        pcMux;
        logic [15:0] pcAddK;
        logic [4:0]  psr;
        logic        halted;
    } snap_t;

    typedef struct {
        logic [15:0] word;
        logic [4:0]  flagsIn;
        int          kind;
        logic        setsFlags;
        logic [7:0]  expOpcode;
        logic [15:0] expWen;
        logic [3:0]  expRdest;
        logic [3:0]  expRsrc;
        logic [15:0] expImm;
        logic        expImmSel;
        logic        expPcMux;
        logic [15:0] expPcAddK;
    } vec_t;

    typedef struct {
        snap_t exp;
        int    vecIdx;
        int    cyc;
    } sbEntry_t;

    vec_t       vecs[NVEC];
    sbEntry_t   sbQueue[$];
    sbEntry_t   sbHead;
    logic [4:0] psrModel;
    int         testsRun = 0;
    int         testsFailed = 0;

    function automatic vec_t mkVec(logic [15:0] w, logic [4:0] f, int k, logic sf,
                                   logic [7:0] op, logic [15:0] wen, logic [3:0] rd,
                                   logic [3:0] rs, logic [15:0] imm, logic isel,
                                   logic pm, logic [15:0] ak);
        vec_t v;
        v.word = w; v.flagsIn = f; v.kind = k; v.setsFlags = sf;
        v.expOpcode = op; v.expWen = wen; v.expRdest = rd; v.expRsrc = rs;
        v.expImm = imm; v.expImmSel = isel; v.expPcMux = pm; v.expPcAddK = ak;
        return v;
    endfunction

    function automatic snap_t actualSnap();
        snap_t s;
        s.opcode = opcode; s.wEnable = wEnable; s.rdest = Rdest_select;
        s.rsrc = Rsrc_select; s.imm = Imm_in; s.immSel = Imm_select;
        s.fam = fsm_alu_mem_selct; s.lsc = lsc_mux_selct; s.enA = en_a;
        s.weA = we_a; s.pcEn = pc_en; s.pcMux = pc_mux_selct;
        s.pcAddK = pc_add_k; s.psr = psr; s.halted = halted;
        return s;
    endfunction

    function automatic snap_t idleSnap(logic enA, logic [4:0] p, logic h);
        snap_t s;
        s = '0;
        s.enA = enA;
        s.psr = p;
        s.halted = h;
        return s;
    endfunction

    // Expected outputs for cycle c of a vector: 0 FETCH, 1 DECODE, 2 EXEC/MEM, 3 WB
    function automatic snap_t expectedSnap(vec_t v, int c, logic [4:0] p);
        snap_t s;
        s = idleSnap(1'b0, p, 1'b0);
        if (c == 0) begin
            s.enA = 1'b1;
        end else if (c == 2 && v.kind == K_EXEC) begin
            s.opcode = v.expOpcode; s.wEnable = v.expWen; s.rdest = v.expRdest;
            s.rsrc = v.expRsrc; s.imm = v.expImm; s.immSel = v.expImmSel;
            s.pcMux = v.expPcMux; s.pcAddK = v.expPcAddK; s.pcEn = 1'b1;
        end else if (c == 2) begin
            s.lsc = 1'b1; s.enA = 1'b1; s.rdest = v.expRdest;
            if (v.kind == K_STOR) begin
                s.rsrc = v.expRsrc; s.weA = 1'b1; s.pcEn = 1'b1;
            end
        end else if (c == 3) begin
            s.lsc = 1'b1; s.fam = 1'b1; s.wEnable = v.expWen; s.pcEn = 1'b1;
        end
        return s;
    endfunction

    task automatic checkOutput(input string name, input snap_t actual, input snap_t expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input snap_t s, input int idx, input int c);
        sbEntry_t e;
        e.exp = s;
        e.vecIdx = idx;
        e.cyc = c;
        sbQueue.push_back(e);
    endtask

    // Entered #1 after the edge that put the DUT in FETCH; leaves likewise
    task automatic applyStimulus(input int idx);
        vec_t v;
        int   nCyc;
        v = vecs[idx];
        nCyc = (v.kind == K_LOAD) ? 4 : 3;
        ram_out = v.word;
        flags_in = v.flagsIn;
        pc_count = 16'(idx);
        for (int c = 0; c < nCyc; c++) begin
            pushExpected(expectedSnap(v, c, psrModel), idx, c);
            @(posedge clk);
            #1;
        end
        if (v.setsFlags) psrModel = v.flagsIn;
    endtask

    always @(negedge clk) begin
        if (sbQueue.size() > 0) begin
            sbHead = sbQueue.pop_front();
            checkOutput($sformatf("vec%0d_cyc%0d", sbHead.vecIdx, sbHead.cyc),
                        actualSnap(), sbHead.exp);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t st;
        //                 word      flags     kind    sf  opc    wEn       rd  rs  imm       is  pm  addK
        vecs[0]  = mkVec(16'h5105, 5'b10000, K_EXEC, 1, 8'h50, 16'h0002, 1,  0,  16'h0005, 1,  0,  16'h0000);
        vecs[1]  = mkVec(16'h59FF, 5'b00000, K_EXEC, 1, 8'h50, 16'h0200, 9,  0,  16'hFFFF, 1,  0,  16'h0000);
        vecs[2]  = mkVec(16'h13FF, 5'b11111, K_EXEC, 0, 8'h10, 16'h0008, 3,  0,  16'h00FF, 1,  0,  16'h0000);
        vecs[3]  = mkVec(16'hF2AB, 5'b00000, K_EXEC, 0, 8'hD0, 16'h0004, 2,  0,  16'hAB00, 1,  0,  16'h0000);
        vecs[4]  = mkVec(16'h4304, 5'b11111, K_LOAD, 0, 8'h00, 16'h0008, 4,  0,  16'h0000, 0,  0,  16'h0000);
        vecs[5]  = mkVec(16'h4546, 5'b11111, K_STOR, 0, 8'h00, 16'h0000, 6,  5,  16'h0000, 0,  0,  16'h0000);
        vecs[6]  = mkVec(16'h01B2, 5'b00010, K_EXEC, 1, 8'h0B, 16'h0000, 1,  2,  16'h0000, 0,  0,  16'h0000);
        vecs[7]  = mkVec(16'hC0FE, 5'b00000, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  1,  16'hFFFE);
        vecs[8]  = mkVec(16'h01B2, 5'b00000, K_EXEC, 1, 8'h0B, 16'h0000, 1,  2,  16'h0000, 0,  0,  16'h0000);
        vecs[9]  = mkVec(16'hC0FE, 5'b00010, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  0,  16'hFFFE);
        vecs[10] = mkVec(16'h0A51, 5'b01001, K_EXEC, 1, 8'h05, 16'h0400, 10, 1,  16'h0000, 0,  0,  16'h0000);
        vecs[11] = mkVec(16'hCE10, 5'b00000, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  1,  16'h0010);
        vecs[12] = mkVec(16'hCF10, 5'b00000, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  0,  16'h0010);
        vecs[13] = mkVec(16'hC6F0, 5'b00000, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  1,  16'hFFF0);
        vecs[14] = mkVec(16'h7123, 5'b11111, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  0,  16'h0000);
        vecs[15] = mkVec(16'h4714, 5'b11111, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  0,  16'h0000);
        vecs[16] = mkVec(16'hB37F, 5'b00001, K_EXEC, 1, 8'hB0, 16'h0000, 3,  0,  16'h007F, 1,  0,  16'h0000);
        vecs[17] = mkVec(16'h0DD7, 5'b11111, K_EXEC, 0, 8'h0D, 16'h2000, 13, 7,  16'h0000, 0,  0,  16'h0000);
        vecs[18] = mkVec(16'hCC05, 5'b00000, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  0,  16'h0005);
        vecs[19] = mkVec(16'h2480, 5'b00000, K_EXEC, 0, 8'h20, 16'h0010, 4,  0,  16'h0080, 1,  0,  16'h0000);
        vecs[20] = mkVec(16'h9880, 5'b00100, K_EXEC, 1, 8'h90, 16'h0100, 8,  0,  16'hFF80, 1,  0,  16'h0000);
        vecs[21] = mkVec(16'hC8F8, 5'b00000, K_EXEC, 0, 8'h00, 16'h0000, 0,  0,  16'h0000, 0,  1,  16'hFFF8);

        reset = 1'b1;
        ram_out = 16'h0000;
        flags_in = 5'b00000;
        pc_count = 16'h0000;
        psrModel = 5'b00000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetState", actualSnap(), idleSnap(1'b1, 5'b00000, 1'b0));
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(i);
        end

        // Store interrupted by reset while in MEM: we_a must fall at once
        st = mkVec(16'h4546, 5'b11111, K_STOR, 0, 8'h00, 16'h0000, 6, 5, 16'h0000, 0, 0, 16'h0000);
        ram_out = st.word;
        flags_in = st.flagsIn;
        for (int c = 0; c < 3; c++) begin
            pushExpected(expectedSnap(st, c, psrModel), 100, c);
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("resetMidStore", actualSnap(), idleSnap(1'b1, 5'b00000, 1'b0));
        psrModel = 5'b00000;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // WAIT parks the FSM; pc_en must stay low from then on
        ram_out = 16'h0000;
        flags_in = 5'b11111;
        pushExpected(idleSnap(1'b1, psrModel, 1'b0), 200, 0);
        @(posedge clk);
        #1;
        pushExpected(idleSnap(1'b0, psrModel, 1'b0), 200, 1);
        @(posedge clk);
        #1;
        for (int c = 2; c < 8; c++) begin
            ram_out = 16'h5105;
            pushExpected(idleSnap(1'b0, psrModel, 1'b1), 200, c);
            @(posedge clk);
            #1;
        end

        checkCount("scoreboardDrained", sbQueue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
